nas_vid_cap: RTL

NAS_VID_CAP -- requirements
Module: nas_vid_cap

---
 rtl/nas_vid_cap_pkg.sv | 27 ++
 rtl/nas_vid_sync_sep.sv | 75 +++++++
 rtl/nas_vid_cap.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/nas_vid_cap_pkg.sv
// Shared types and constants for the NAS video capture block.
package nas_vid_cap_pkg;

    localparam int unsigned ADDR_W     = 14;
    localparam int unsigned LINE_PITCH = 64;
    localparam int unsigned COL_W      = $clog2(LINE_PITCH);

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_VSKIP,
        ST_HWAIT,
        ST_CAPTURE,
        ST_DONE
    } cap_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } cap_wr_t;

    // Frame-buffer address of a byte: one LINE_PITCH-wide row per raster line.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] line,
                                                   input logic [ADDR_W-1:0] col);
        return ADDR_W'(line * ADDR_W'(LINE_PITCH)) + col;
    endfunction

endpackage

// File: rtl/nas_vid_sync_sep.sv
// Sync separator: 2-flop synchronisers plus sync-low width classifier (hsync / vsync pulses).
module nas_vid_sync_sep #(
    parameter int unsigned HSYNC_MIN = 32,
    parameter int unsigned VSYNC_MIN = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic vid_sync,
    input  logic vid_data,
    output logic hsync_p,
    output logic vsync_p,
    output logic data_s
);

    localparam int unsigned WID_W = $clog2(VSYNC_MIN + 1);

    logic             sync1_q, sync2_q, data1_q, data2_q, prev_q;
    logic             armed_q, armed_d;
    logic [WID_W-1:0] wid_q, wid_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;

    // A pulse is only classified once a falling edge has been seen since reset.
    always_comb begin
        armed_d = armed_q;
        wid_d   = wid_q;
        hsync_d = 1'b0;
        vsync_d = 1'b0;
        if (!sync2_q) begin
            if (wid_q != WID_W'(VSYNC_MIN)) begin
                wid_d = wid_q + WID_W'(1);
            end
            if (prev_q) begin
                armed_d = 1'b1;
            end
        end else begin
            wid_d = '0;
            if (!prev_q && armed_q) begin
                if (wid_q >= WID_W'(VSYNC_MIN)) begin
                    vsync_d = 1'b1;
                end else if (wid_q >= WID_W'(HSYNC_MIN)) begin
                    hsync_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            data1_q <= 1'b0;
            data2_q <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            wid_q   <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            sync1_q <= vid_sync;
            sync2_q <= sync1_q;
            data1_q <= vid_data;
            data2_q <= data1_q;
            prev_q  <= sync2_q;
            armed_q <= armed_d;
            wid_q   <= wid_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign hsync_p = hsync_q;
    assign vsync_p = vsync_q;
    assign data_s  = data2_q;

endmodule

// File: rtl/nas_vid_cap.sv
// 1bpp composite video frame grabber; writes captured bytes to a line*64+col address map.
// Optional frame/error statistics enabled by macro NAS_VID_CAP_STATS_EN.
module nas_vid_cap
    import nas_vid_cap_pkg::*;
#(
    parameter int unsigned HSYNC_MIN = 32,
    parameter int unsigned VSYNC_MIN = 256,
    parameter int unsigned V_OFFSET  = 16,
    parameter int unsigned H_OFFSET  = 160,
    parameter int unsigned H_BYTES   = 48,
    parameter int unsigned LINES     = 224
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_sync,
    input  logic              vid_data,
    output logic              cap_we,
    output logic [ADDR_W-1:0] cap_addr,
    output logic [7:0]        cap_data,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              sync_err
);

    localparam int unsigned VCNT_W = $clog2(V_OFFSET + 1);
    localparam int unsigned HCNT_W = $clog2(H_OFFSET + 1);
    localparam int unsigned LINE_W = $clog2(LINES + 1);

    logic hsync_p, vsync_p, data_s;

    nas_vid_sync_sep #(
        .HSYNC_MIN (HSYNC_MIN),
        .VSYNC_MIN (VSYNC_MIN)
    ) u_sync_sep (
        .clk      (clk),
        .reset_n  (reset_n),
        .vid_sync (vid_sync),
        .vid_data (vid_data),
        .hsync_p  (hsync_p),
        .vsync_p  (vsync_p),
        .data_s   (data_s)
    );

    cap_state_e        state_q, state_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              phase_q, phase_d;
    logic [2:0]        bitn_q, bitn_d;
    logic [6:0]        shift_q, shift_d;
    logic              full_q, full_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    cap_wr_t           wr_q, wr_d;
    logic              abort_c;

    assign abort_c = vsync_p && (state_q inside {ST_VSKIP, ST_HWAIT, ST_CAPTURE});

    always_comb begin
        state_d = state_q;
        vcnt_d  = vcnt_q;
        hcnt_d  = hcnt_q;
        line_d  = line_q;
        col_d   = col_q;
        phase_d = phase_q;
        bitn_d  = bitn_q;
        shift_d = shift_q;
        full_d  = full_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        wr_d    = wr_q;

        case (state_q)
            ST_HUNT: ;
            ST_VSKIP: begin
                if (hsync_p) begin
                    if (vcnt_q == VCNT_W'(V_OFFSET - 1)) begin
                        state_d = ST_HWAIT;
                        hcnt_d  = '0;
                    end else begin
                        vcnt_d = vcnt_q + VCNT_W'(1);
                    end
                end
            end
            ST_HWAIT: begin
                if (hsync_p) begin
                    hcnt_d = '0;
                end else if (hcnt_q == HCNT_W'(H_OFFSET - 1)) begin
                    state_d = ST_CAPTURE;
                    phase_d = 1'b0;
                    bitn_d  = '0;
                    full_d  = 1'b0;
                end else begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                // Sample on alternate cycles; the 8th sample goes straight into the write.
                if (!full_q) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        shift_d = {shift_q[5:0], data_s};
                        bitn_d  = bitn_q + 3'd1;
                        if (bitn_q == 3'd7) begin
                            we_d      = 1'b1;
                            wr_d.addr = pix_addr(ADDR_W'(line_q), ADDR_W'(col_q));
                            wr_d.data = {shift_q, data_s};
                            if (col_q == COL_W'(H_BYTES - 1)) begin
                                col_d  = '0;
                                line_d = line_q + LINE_W'(1);
                                full_d = 1'b1;
                                if (line_q == LINE_W'(LINES - 1)) begin
                                    state_d = ST_DONE;
                                end
                            end else begin
                                col_d = col_q + COL_W'(1);
                            end
                        end
                    end
                end
                // An early hsync closes a short line; its partial byte is dropped.
                if (hsync_p && state_d == ST_CAPTURE) begin
                    state_d = ST_HWAIT;
                    hcnt_d  = '0;
                    if (!full_d) begin
                        col_d  = '0;
                        line_d = line_q + LINE_W'(1);
                        if (line_q == LINE_W'(LINES - 1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_HUNT;
            end
            default: state_d = ST_HUNT;
        endcase

        if (vsync_p && state_q != ST_DONE) begin
            state_d = ST_VSKIP;
            vcnt_d  = '0;
            line_d  = '0;
            col_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_HUNT;
            vcnt_q  <= '0;
            hcnt_q  <= '0;
            line_q  <= '0;
            col_q   <= '0;
            phase_q <= 1'b0;
            bitn_q  <= '0;
            shift_q <= '0;
            full_q  <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            vcnt_q  <= vcnt_d;
            hcnt_q  <= hcnt_d;
            line_q  <= line_d;
            col_q   <= col_d;
            phase_q <= phase_d;
            bitn_q  <= bitn_d;
            shift_q <= shift_d;
            full_q  <= full_d;
            we_q    <= we_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
        end
    end

    assign cap_we     = we_q;
    assign cap_addr   = wr_q.addr;
    assign cap_data   = wr_q.data;
    assign frame_done = done_q;

`ifdef NAS_VID_CAP_STATS_EN
    logic [7:0] fcnt_q, fcnt_d;
    logic       err_q, err_d;

    always_comb begin
        fcnt_d = fcnt_q + 8'(done_d);
        err_d  = abort_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            err_q  <= err_d;
        end
    end

    assign frame_cnt = fcnt_q;
    assign sync_err  = err_q;
`else
    assign frame_cnt = '0;
    assign sync_err  = 1'b0;
`endif

endmodule
